// File: rtl/tla_adc_decim.sv
// tla_adc_decim: multi-channel ADC decimator for the 125 MHz capture domain.
// Emits one vector per 2^k valid beats, either the first sample or the floor average.
module tla_adc_decim #(
  parameter int CH_NUM   = 4,
  parameter int ADC_W    = 14,
  parameter int MAX_LOG2 = 4,
  parameter int LOG2_W   = 3
) (
  input  logic                      Gc_clk125,
  input  logic                      Gc_rst_n,
  input  logic                      Gc_en,
  input  logic                      Gc_mode,
  input  logic [LOG2_W-1:0]         Gc_dec_log2,
  input  logic                      Gc_in_vld,
  input  logic [CH_NUM-1:0]         Gc_in_of,
  input  logic [CH_NUM*ADC_W-1:0]   Gc_in_data,
  output logic                      Gc_out_vld,
  output logic [CH_NUM-1:0]         Gc_out_of,
  output logic [CH_NUM*ADC_W-1:0]   Gc_out_data,
  input  logic                      Gc_of_clr,
  output logic [CH_NUM-1:0]         Gc_of_sticky
);

  localparam int ACC_W  = ADC_W + MAX_LOG2;
  localparam int SPAN_W = MAX_LOG2 + 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACC  = 1'b1;

  logic                     run_q;
  logic [0:0]               state_q;
  logic [MAX_LOG2-1:0]      cnt_q;
  logic                     mode_q;
  logic [LOG2_W-1:0]        k_q;
  logic signed [ACC_W-1:0]  acc_q [CH_NUM];
  logic [CH_NUM-1:0]        of_acc_q;

  logic [LOG2_W-1:0]        k_clamp;
  logic [LOG2_W-1:0]        k_eff;
  logic                     mode_eff;
  logic                     first;
  logic                     last;
  logic                     beat;
  logic [SPAN_W-1:0]        span_m1;
  logic [CH_NUM-1:0]        of_sum;
  logic signed [ACC_W-1:0]  sum_c [CH_NUM];
  logic signed [ACC_W-1:0]  shifted_c [CH_NUM];
  logic [CH_NUM*ADC_W-1:0]  res;

  // Reset release is retimed so every other register starts on a clean edge.
  always_ff @(posedge Gc_clk125 or negedge Gc_rst_n) begin
    if (!Gc_rst_n) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  // The first beat of a window sees the live config, later beats the latched one.
  always_comb begin
    k_clamp  = (Gc_dec_log2 > LOG2_W'(MAX_LOG2)) ? LOG2_W'(MAX_LOG2) : Gc_dec_log2;
    first    = (cnt_q == '0);
    k_eff    = first ? k_clamp : k_q;
    mode_eff = first ? Gc_mode : mode_q;
    span_m1  = (SPAN_W'(1) << k_eff) - SPAN_W'(1);
    last     = ({1'b0, cnt_q} == span_m1);
    beat     = run_q && (state_q == ST_ACC) && Gc_en && Gc_in_vld;
    of_sum   = first ? Gc_in_of : (of_acc_q | Gc_in_of);
    res      = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      sum_c[c]     = '0;
      shifted_c[c] = '0;
    end
    for (int c = 0; c < CH_NUM; c++) begin
      if (first) begin
        sum_c[c] = ACC_W'(signed'(Gc_in_data[c*ADC_W +: ADC_W]));
      end else if (mode_eff) begin
        sum_c[c] = acc_q[c] + ACC_W'(signed'(Gc_in_data[c*ADC_W +: ADC_W]));
      end else begin
        sum_c[c] = acc_q[c];
      end
      shifted_c[c] = mode_eff ? (sum_c[c] >>> k_eff) : sum_c[c];
      res[c*ADC_W +: ADC_W] = shifted_c[c][ADC_W-1:0];
    end
  end

  // Dropping enable discards the partial window and rewinds the counter.
  always_ff @(posedge Gc_clk125 or negedge Gc_rst_n) begin
    if (!Gc_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      k_q     <= '0;
    end else if (run_q) begin
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (Gc_en) begin
            state_q <= ST_ACC;
          end
        end
        default: begin
          if (!Gc_en) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else if (beat) begin
            if (first) begin
              mode_q <= Gc_mode;
              k_q    <= k_clamp;
            end
            cnt_q <= last ? '0 : cnt_q + MAX_LOG2'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge Gc_clk125 or negedge Gc_rst_n) begin
    if (!Gc_rst_n) begin
      for (int c = 0; c < CH_NUM; c++) begin
        acc_q[c] <= '0;
      end
      of_acc_q <= '0;
    end else if (run_q && beat) begin
      for (int c = 0; c < CH_NUM; c++) begin
        acc_q[c] <= sum_c[c];
      end
      of_acc_q <= of_sum;
    end
  end

  // Output registers hold the last result between strobes.
  always_ff @(posedge Gc_clk125 or negedge Gc_rst_n) begin
    if (!Gc_rst_n) begin
      Gc_out_vld  <= 1'b0;
      Gc_out_of   <= '0;
      Gc_out_data <= '0;
    end else if (run_q) begin
      Gc_out_vld <= beat && last;
      if (beat && last) begin
        Gc_out_of   <= of_sum;
        Gc_out_data <= res;
      end
    end
  end

  // A new overflow strobe wins over a simultaneous clear.
  always_ff @(posedge Gc_clk125 or negedge Gc_rst_n) begin
    if (!Gc_rst_n) begin
      Gc_of_sticky <= '0;
    end else if (run_q) begin
      Gc_of_sticky <= (Gc_of_sticky & ~{CH_NUM{Gc_of_clr}}) |
                      (Gc_out_vld ? Gc_out_of : '0);
    end
  end

endmodule

// File: tb/tb_tla_adc_decim.sv
// tb_tla_adc_decim: directed and random stimulus for tla_adc_decim, checked
// against a window-level reference model using integer floor division.
module tb_tla_adc_decim;

  localparam int CH = 4;
  localparam int W  = 14;
  localparam int ML = 4;
  localparam int LW = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic              mode = 1'b0;
  logic [LW-1:0]     dec = '0;
  logic              in_vld = 1'b0;
  logic [CH-1:0]     in_of = '0;
  logic [CH*W-1:0]   in_data = '0;
  logic              of_clr = 1'b0;
  logic              out_vld;
  logic [CH-1:0]     out_of;
  logic [CH*W-1:0]   out_data;
  logic [CH-1:0]     of_sticky;

  tla_adc_decim #(.CH_NUM(CH), .ADC_W(W), .MAX_LOG2(ML), .LOG2_W(LW)) dut (
    .Gc_clk125   (clk),
    .Gc_rst_n    (rst_n),
    .Gc_en       (en),
    .Gc_mode     (mode),
    .Gc_dec_log2 (dec),
    .Gc_in_vld   (in_vld),
    .Gc_in_of    (in_of),
    .Gc_in_data  (in_data),
    .Gc_out_vld  (out_vld),
    .Gc_out_of   (out_of),
    .Gc_out_data (out_data),
    .Gc_of_clr   (of_clr),
    .Gc_of_sticky(of_sticky)
  );

  always #4 clk = ~clk;

  int nCmp = 0;
  int nFail = 0;
  string stepName = "init";

  logic [CH*W-1:0] winData[$];
  logic [CH-1:0]   winOf[$];
  int              winK = 0;
  logic            winMode = 1'b0;
  logic            mAcc = 1'b0;
  logic            expVld = 1'b0;
  logic [CH*W-1:0] expData = '0;
  logic [CH-1:0]   expOf = '0;
  logic [CH-1:0]   expSticky = '0;

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s/%s observed=%0h expected=%0h", stepName, tag, obs, exp);
    end
  endtask

  function automatic logic [CH*W-1:0] windowResult();
    logic [CH*W-1:0] r;
    logic [CH*W-1:0] v;
    int sum, first, q, d;
    r = '0;
    for (int c = 0; c < CH; c++) begin
      sum = 0;
      first = 0;
      for (int i = 0; i < winData.size(); i++) begin
        v = winData[i];
        if (i == 0) first = int'($signed(v[c*W +: W]));
        sum += int'($signed(v[c*W +: W]));
      end
      if (winMode) begin
        d = 1 << winK;
        q = sum / d;
        if ((sum % d != 0) && (sum < 0)) q = q - 1;
      end else begin
        q = first;
      end
      r[c*W +: W] = q[W-1:0];
    end
    return r;
  endfunction

  function automatic logic [CH*W-1:0] mkData(input int ch, input logic [W-1:0] val);
    logic [CH*W-1:0] r;
    for (int i = 0; i < CH; i++) r[i*W +: W] = W'($urandom);
    r[ch*W +: W] = val;
    return r;
  endfunction

  task automatic checkOutput();
    checkVal("out_vld", 64'(out_vld), 64'(expVld));
    checkVal("out_data", 64'(out_data), 64'(expData));
    checkVal("out_of", 64'(out_of), 64'(expOf));
    checkVal("sticky", 64'(of_sticky), 64'(expSticky));
  endtask

  // One clock cycle: drive inputs, advance the model, compare everything.
  task automatic applyStimulus(input logic vld, input logic [CH*W-1:0] d,
                               input logic [CH-1:0] o, input logic clr);
    logic            prevVld;
    logic [CH-1:0]   prevOf;
    logic [CH-1:0]   orOf;
    in_vld = vld;
    in_data = d;
    in_of = o;
    of_clr = clr;
    prevVld = expVld;
    prevOf = expOf;
    @(posedge clk);
    #1;
    expVld = 1'b0;
    expSticky = (expSticky & ~{CH{clr}}) | (prevVld ? prevOf : '0);
    if (mAcc && en && vld) begin
      if (winData.size() == 0) begin
        winK = (int'(dec) > ML) ? ML : int'(dec);
        winMode = mode;
      end
      winData.push_back(d);
      winOf.push_back(o);
      if (winData.size() == (1 << winK)) begin
        orOf = '0;
        foreach (winOf[i]) orOf |= winOf[i];
        expVld = 1'b1;
        expData = windowResult();
        expOf = orOf;
        winData.delete();
        winOf.delete();
      end
    end
    if (!en) begin
      winData.delete();
      winOf.delete();
    end
    mAcc = en;
    checkOutput();
    in_vld = 1'b0;
    of_clr = 1'b0;
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, mkData(0, '0), '0, 1'b0);
  endtask

  task automatic flush();
    en = 1'b0;
    gap(1);
    en = 1'b1;
    gap(1);
  endtask

  task automatic modelReset();
    winData.delete();
    winOf.delete();
    mAcc = 1'b0;
    expVld = 1'b0;
    expData = '0;
    expOf = '0;
    expSticky = '0;
  endtask

  logic [W-1:0]    pickVals [4] = '{14'd10, 14'd20, 14'd30, 14'd40};
  logic [W-1:0]    avgVals [4]  = '{14'h3FFF, 14'h3FFE, 14'h3FFE, 14'h3FFE};
  logic [CH*W-1:0] vec;
  logic [CH*W-1:0] allMax;
  logic [CH*W-1:0] all100;

  initial begin
    allMax = {CH{14'h1FFF}};
    all100 = {CH{14'h0100}};

    stepName = "reset";
    #1;
    checkOutput();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    gap(2);
    en = 1'b1;
    gap(2);

    stepName = "pick";
    flush();
    dec = 3'd2;
    mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, mkData(0, pickVals[i]), '0, 1'b0);
      if (i < 3) gap(i);
    end
    checkVal("pick_ch0", 64'(out_data[0 +: W]), 64'd10);
    gap(3);

    stepName = "avg_signed";
    mode = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, mkData(1, avgVals[i]), '0, 1'b0);
    checkVal("avg_ch1", 64'(out_data[W +: W]), 64'h3FFE);
    dec = 3'd4;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, allMax, '0, 1'b0);
      if (i == 7) gap(2);
    end
    checkVal("avg_max", 64'(out_data), 64'(allMax));

    stepName = "k0_stream";
    dec = 3'd0;
    for (int i = 0; i < 8; i++) begin
      mode = 1'($urandom);
      vec = mkData(0, W'($urandom));
      applyStimulus(1'b1, vec, '0, 1'b0);
      checkVal("k0_passthru", 64'(out_data), 64'(vec));
    end

    stepName = "clamp";
    dec = 3'd7;
    mode = 1'b1;
    for (int i = 0; i < 32; i++) applyStimulus(1'b1, mkData(0, W'($urandom)), '0, 1'b0);
    gap(1);

    stepName = "overflow";
    flush();
    dec = 3'd1;
    mode = 1'b0;
    applyStimulus(1'b1, mkData(0, 14'd5), 4'b0000, 1'b0);
    applyStimulus(1'b1, mkData(0, 14'd6), 4'b0100, 1'b0);
    checkVal("of_window", 64'(out_of), 64'b0100);
    gap(1);
    checkVal("of_sticky_set", 64'(of_sticky), 64'b0100);
    applyStimulus(1'b1, mkData(0, 14'd7), 4'b0000, 1'b0);
    applyStimulus(1'b1, mkData(0, 14'd8), 4'b0000, 1'b0);
    gap(1);
    applyStimulus(1'b1, mkData(0, 14'd9), 4'b0100, 1'b0);
    applyStimulus(1'b1, mkData(0, 14'd9), 4'b0000, 1'b0);
    applyStimulus(1'b0, mkData(0, 14'd0), 4'b0000, 1'b1);
    checkVal("set_wins", 64'(of_sticky[2]), 64'd1);
    applyStimulus(1'b0, mkData(0, 14'd0), 4'b0000, 1'b1);
    checkVal("sticky_clr", 64'(of_sticky), 64'd0);

    stepName = "enable_drop";
    flush();
    dec = 3'd3;
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, mkData(0, W'($urandom)), '0, 1'b0);
    en = 1'b0;
    gap(2);
    en = 1'b1;
    gap(1);
    dec = 3'd1;
    applyStimulus(1'b1, mkData(0, 14'd1), '0, 1'b0);
    en = 1'b0;
    applyStimulus(1'b1, mkData(0, 14'd2), '0, 1'b0);
    en = 1'b1;
    gap(1);

    stepName = "cfg_change";
    dec = 3'd3;
    mode = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i == 2) dec = 3'd1;
      applyStimulus(1'b1, mkData(0, W'($urandom)), '0, 1'b0);
    end
    gap(1);

    stepName = "random";
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) dec = LW'($urandom);
      if ($urandom_range(0, 15) == 0) mode = 1'($urandom);
      if ($urandom_range(0, 40) == 0) en = ~en;
      else if (!en) en = 1'b1;
      applyStimulus(1'($urandom_range(0, 3) != 0), mkData(0, W'($urandom)),
                    CH'($urandom_range(0, 7) == 0 ? $urandom : 0),
                    1'($urandom_range(0, 9) == 0));
    end

    stepName = "reset_mid";
    flush();
    dec = 3'd2;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, mkData(0, W'($urandom)), 4'b1111, 1'b0);
    en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput();
    @(posedge clk);
    #3 rst_n = 1'b1;
    gap(1);
    en = 1'b1;
    gap(2);
    mode = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, all100, '0, 1'b0);
    checkVal("post_reset", 64'(out_data), 64'(all100));
    gap(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
